// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer.
// Owns the architectural fetch PC and keeps at most one 8-byte-aligned
// memory request outstanding. The 32-bit word for each fetch PC is extracted
// from the response and queued for decode behind a valid/ready handshake.
// Jump and flush redirects retarget fetch. A discard flag drops the one
// stale response that can still be in flight after a redirect or reset.
//
// Build option: define FETCH_BUF2_EN for a 2-entry instruction buffer, which
// allows the next fetch to overlap a held entry. Otherwise the buffer has
// 1 entry. The port list is the same in both builds.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        jmp_valid,
    input  logic [63:0] jmp_target,
    input  logic        fetch_flush,
    input  logic [63:0] pc_from_flush,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    input  logic        id_ready,
    output logic        misalign
);

`ifdef FETCH_BUF2_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FULL
    } state_t;

    state_t      state_q;
    logic        mem_req_q;
    logic        discard_q;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] req_pc_q,   req_pc_d;
    logic        misalign_q, misalign_d;
    logic [1:0]  cnt_q,      cnt_d;

    // Two physical slots in both builds. Slot 0 is the head. With a 1-entry
    // buffer, slot 1 is never written and only shifts zeros into slot 0.
    logic [63:0] buf_pc_q  [0:1];
    logic [31:0] buf_ins_q [0:1];

    logic        redirect;
    logic [63:0] redir_tgt;
    logic        gnt_fire;
    logic        deq;
    logic        take;
    logic        outstanding_after;
    logic        keep_discard;
    logic [1:0]  cnt_after;
    logic        slot_free;
    logic        wr_idx;
    logic [31:0] instr_sel;

    // Flush comes from a later stage, so it takes priority over a jump.
    assign redirect  = fetch_flush | jmp_valid;
    assign redir_tgt = fetch_flush ? pc_from_flush : jmp_target;

    assign gnt_fire  = (state_q == S_REQ) && mem_gnt;
    assign deq       = if_valid && id_ready;

    // A response is buffered only if it belongs to the current path. That
    // excludes a response marked stale and a response that arrives with a redirect.
    assign take      = mem_rvalid && (state_q == S_WAIT) && !discard_q && !redirect;

    // True when a request is still in flight after this cycle, either
    // because it was just granted or because its response has not come back.
    assign outstanding_after = ((state_q == S_WAIT) && !mem_rvalid) || gnt_fire;
    assign keep_discard      = discard_q && !mem_rvalid;

    assign cnt_after = cnt_q - {1'b0, deq} + {1'b0, take};
    assign slot_free = (cnt_after < DEPTH);

    // The write slot is the occupancy after this cycle's dequeue. A dequeue
    // cannot occur with the buffer empty, and a take cannot occur with the
    // buffer full, so one bit is enough.
    assign wr_idx    = cnt_q[0] ^ deq;

    assign instr_sel = req_pc_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];

    // Next values for the fetch PC, the PC of the outstanding request,
    // the misalign flag and the buffer occupancy.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        misalign_d = misalign_q;
        cnt_d      = cnt_after;
        if (gnt_fire) begin
            req_pc_d = fetch_pc_q;
        end
        if (redirect) begin
            fetch_pc_d = redir_tgt & ~64'h3;
            misalign_d = |redir_tgt[1:0];
            cnt_d      = 2'd0;
        end else if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
        end
    end

    // Control FSM: sequences requests, with a registered mem_req and the discard flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
            // A response to a request made before reset must be dropped.
            discard_q <= outstanding_after | keep_discard;
        end else if (redirect) begin
            discard_q <= outstanding_after | keep_discard;
            if (outstanding_after) begin
                state_q   <= S_WAIT;
                mem_req_q <= 1'b0;
            end else begin
                state_q   <= S_REQ;
                mem_req_q <= 1'b1;
            end
        end else begin
            if (mem_rvalid && discard_q) begin
                discard_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    state_q   <= S_REQ;
                    mem_req_q <= 1'b1;
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        state_q   <= S_WAIT;
                        mem_req_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (slot_free) begin
                            state_q   <= S_REQ;
                            mem_req_q <= 1'b1;
                        end else begin
                            state_q   <= S_FULL;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                S_FULL: begin
                    if (deq) begin
                        state_q   <= S_REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Registers for the fetch PC, the request PC, the misalign flag and the occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC & ~64'h3;
            req_pc_q   <= '0;
            misalign_q <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    // Shift FIFO. The head moves up on a dequeue. A held head is never
    // overwritten because a take writes only at the slot behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                buf_pc_q[i]  <= '0;
                buf_ins_q[i] <= '0;
            end
        end else begin
            if (deq) begin
                buf_pc_q[0]  <= buf_pc_q[1];
                buf_ins_q[0] <= buf_ins_q[1];
            end
            if (take) begin
                buf_pc_q[wr_idx]  <= req_pc_q;
                buf_ins_q[wr_idx] <= instr_sel;
            end
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = {fetch_pc_q[63:3], 3'b000};
    assign if_valid = (cnt_q != 2'd0);
    assign if_pc    = buf_pc_q[0];
    assign if_instr = buf_ins_q[0];
    assign misalign = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl. A memory model grants requests and returns the
// response one cycle later, and can delay the response. Stimulus pushes the
// expected decode outputs into a queue, and a monitor pops and compares each
// handshake.
module tb_fetch_ctrl;
    localparam logic [63:0] RPC = 64'h1000;
`ifdef FETCH_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        jmp_valid;
    logic [63:0] jmp_target;
    logic        fetch_flush;
    logic [63:0] pc_from_flush;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic        misalign;

    fetch_ctrl #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .fetch_flush(fetch_flush), .pc_from_flush(pc_from_flush),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] gnt_log[$];
    int          total;
    int          bad;
    bit          gnt_en;
    bit          hold_resp;

    // The word stored at pc in the memory model.
    function automatic logic [31:0] ins_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [63:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = ins_of(pc);
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait, within a cycle limit, until every expected output has been seen.
    // Then stop decode before the next sample, so later fetches are not consumed.
    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step(1);
            n++;
        end
        id_ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: pending outputs got %0d want 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Put the DUT in a known state: jump to t with decode and grants
    // stopped, and let any stale response complete. The DUT is left in REQ
    // at t with an empty buffer.
    task automatic park(input logic [63:0] t);
        id_ready   = 1'b0;
        gnt_en     = 1'b0;
        jmp_valid  = 1'b1;
        jmp_target = t;
        step(1);
        jmp_valid  = 1'b0;
        step(3);
    endtask

    // Memory model: same-cycle grant and a response one cycle later, unless held.
    initial begin
        bit          pend;
        logic [63:0] pend_addr;
        pend       = 1'b0;
        pend_addr  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (pend && !hold_resp) begin
                mem_rvalid = 1'b1;
                mem_rdata  = {ins_of(pend_addr + 64'd4), ins_of(pend_addr)};
                pend       = 1'b0;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
            mem_gnt = mem_req && gnt_en;
            if (mem_gnt) begin
                pend      = 1'b1;
                pend_addr = mem_addr;
                gnt_log.push_back(mem_addr);
            end
        end
    end

    // Monitor: compares every handshake with the head of the expected queue
    // and checks that a held output stays stable.
    initial begin
        exp_t        e;
        bit          hold_prev;
        logic [63:0] hpc;
        logic [31:0] hins;
        hold_prev = 1'b0;
        hpc       = '0;
        hins      = '0;
        forever begin
            @(negedge clk);
            if (hold_prev && if_valid) begin
                chk("hold_pc", if_pc, hpc);
                chk("hold_instr", 64'(if_instr), 64'(hins));
            end
            if (if_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got pc %h want none", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", if_pc, e.pc);
                    chk("out_instr", 64'(if_instr), 64'(e.ins));
                end
            end
            hold_prev = if_valid && !id_ready && !reset;
            hpc       = if_pc;
            hins      = if_instr;
        end
    end

    // Directed stimulus.
    initial begin
        total         = 0;
        bad           = 0;
        gnt_en        = 1'b1;
        hold_resp     = 1'b0;
        reset         = 1'b1;
        id_ready      = 1'b1;
        jmp_valid     = 1'b0;
        jmp_target    = '0;
        fetch_flush   = 1'b0;
        pc_from_flush = '0;

        // Reset values, then the first sequential fetches.
        step(2);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", mem_addr, RPC);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_if_instr", 64'(if_instr), 64'd0);
        chk("rst_if_pc", if_pc, 64'd0);
        chk("rst_misalign", 64'(misalign), 64'd0);
        gnt_log.delete();
        expect_pc(64'h1000);
        expect_pc(64'h1004);
        expect_pc(64'h1008);
        reset = 1'b0;
        chk("idle_no_req", 64'(mem_req), 64'd0);
        step(1);
        chk("first_req", 64'(mem_req), 64'd1);
        chk("first_addr", mem_addr, 64'h1000);
        drain("seq_drain");
        chk("seq_ngnt", 64'(gnt_log.size() >= 3), 64'd1);
        if (gnt_log.size() >= 3) begin
            chk("seq_addr0", gnt_log[0], 64'h1000);
            chk("seq_addr1", gnt_log[1], 64'h1000);
            chk("seq_addr2", gnt_log[2], 64'h1008);
        end

        // Decode stalled for 5 cycles: the buffer fills to its depth and requests stop.
        park(64'h1100);
        gnt_log.delete();
        gnt_en = 1'b1;
        step(4);
        chk("full_no_req", 64'(mem_req), 64'd0);
        chk("full_valid", 64'(if_valid), 64'd1);
        step(1);
        chk("full_no_req2", 64'(mem_req), 64'd0);
        chk("full_head_pc", if_pc, 64'h1100);
        chk("full_buffered", 64'(gnt_log.size()), 64'(DEPTH));
        expect_pc(64'h1100);
        expect_pc(64'h1104);
        expect_pc(64'h1108);
        expect_pc(64'h110C);
        id_ready = 1'b1;
        drain("stall_drain");

        // Jump in WAIT: the pending response is dropped.
        park(64'h1F00);
        id_ready  = 1'b1;
        gnt_en    = 1'b1;
        hold_resp = 1'b1;
        step(1);
        chk("wait_no_req", 64'(mem_req), 64'd0);
        jmp_valid  = 1'b1;
        jmp_target = 64'h2000;
        expect_pc(64'h2000);
        expect_pc(64'h2004);
        step(1);
        jmp_valid = 1'b0;
        chk("jmp_if_valid", 64'(if_valid), 64'd0);
        hold_resp = 1'b0;
        step(1);
        chk("jmp_addr", mem_addr, 64'h2000);
        chk("jmp_req", 64'(mem_req), 64'd1);
        chk("jmp_drop_valid", 64'(if_valid), 64'd0);
        drain("jmp_drain");

        // A flush has priority over a jump in the same cycle.
        park(64'h2F00);
        jmp_valid     = 1'b1;
        jmp_target    = 64'h3000;
        fetch_flush   = 1'b1;
        pc_from_flush = 64'h4000;
        expect_pc(64'h4000);
        step(1);
        jmp_valid   = 1'b0;
        fetch_flush = 1'b0;
        chk("prio_addr", mem_addr, 64'h4000);
        chk("prio_req", 64'(mem_req), 64'd1);
        id_ready = 1'b1;
        gnt_en   = 1'b1;
        drain("prio_drain");

        // A misaligned target sets misalign, and an aligned jump clears it.
        park(64'h4F00);
        jmp_valid  = 1'b1;
        jmp_target = 64'h5002;
        expect_pc(64'h5000);
        step(1);
        jmp_valid = 1'b0;
        chk("mis_set", 64'(misalign), 64'd1);
        chk("mis_addr", mem_addr, 64'h5000);
        id_ready = 1'b1;
        gnt_en   = 1'b1;
        drain("mis_drain");
        park(64'h6000);
        chk("mis_clr", 64'(misalign), 64'd0);
        chk("mis_clr_addr", mem_addr, 64'h6000);
        expect_pc(64'h6000);
        id_ready = 1'b1;
        gnt_en   = 1'b1;
        drain("mis_clr_drain");

        // Reset in WAIT, with the response arriving after reset.
        park(64'h7001);
        chk("pre_rst_mis", 64'(misalign), 64'd1);
        gnt_en    = 1'b1;
        hold_resp = 1'b1;
        step(1);
        chk("pre_rst_wait", 64'(mem_req), 64'd0);
        reset    = 1'b1;
        gnt_en   = 1'b0;
        id_ready = 1'b1;
        step(1);
        chk("mid_rst_req", 64'(mem_req), 64'd0);
        chk("mid_rst_addr", mem_addr, RPC);
        chk("mid_rst_valid", 64'(if_valid), 64'd0);
        chk("mid_rst_instr", 64'(if_instr), 64'd0);
        chk("mid_rst_pc", if_pc, 64'd0);
        chk("mid_rst_mis", 64'(misalign), 64'd0);
        step(1);
        chk("mid_rst_req2", 64'(mem_req), 64'd0);
        gnt_log.delete();
        expect_pc(RPC);
        reset     = 1'b0;
        hold_resp = 1'b0;
        gnt_en    = 1'b1;
        step(1);
        chk("post_rst_req", 64'(mem_req), 64'd1);
        chk("post_rst_addr", mem_addr, RPC);
        drain("post_rst_drain");
        chk("post_rst_ngnt", 64'(gnt_log.size() > 0), 64'd1);
        if (gnt_log.size() > 0) begin
            chk("post_rst_gnt0", gnt_log[0], RPC);
        end

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit, in case the stimulus stops making progress.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want test done");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer between the PC-increment logic and the instruction memory port. It owns the architectural fetch PC and issues one 8-byte-aligned memory request at a time. It extracts the 32-bit instruction for the current PC and presents it to decode over a valid/ready handshake. Jump and flush redirects retarget fetch and discard stale in-flight data, so decode never sees a wrong-path instruction.

## Interface
- RESET_PC, 64'h0, fetch PC loaded on reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- mem_req  out  1  request valid; held until mem_gnt
- mem_addr  out  64  {pc[63:3],3'b000}; stable while mem_req && !mem_gnt, except when a redirect retargets it
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response for the single outstanding request
- mem_rdata  in  64  response data
- jmp_valid  in  1  jump redirect pulse
- jmp_target  in  64  jump destination
- fetch_flush  in  1  flush redirect pulse from a later stage
- pc_from_flush  in  64  flush destination
- if_valid  out  1  instruction available to decode
- if_instr  out  32  pc[2] ? rdata[63:32] : rdata[31:0]
- if_pc  out  64  PC of if_instr
- id_ready  in  1  decode accepts this cycle
- misalign  out  1  sticky: last redirect target had bits [1:0] != 0

## Operation
- States:
  - IDLE: one cycle after reset.
  - REQ: mem_req=1.
  - WAIT: outstanding request, mem_req=0.
  - FULL: buffer has no free slot, no request.
- Transitions:
  - IDLE -> REQ.
  - REQ -> WAIT on mem_gnt.
  - WAIT -> REQ on mem_rvalid when a slot is free after that cycle's dequeue; otherwise WAIT -> FULL.
  - FULL -> REQ when a dequeue (if_valid && id_ready) frees a slot.
- Issue rule: a request may issue only when buffer occupancy plus outstanding requests is less than the buffer depth. At most one outstanding request.
- Fetch PC: after each grant, fetch_pc <= fetch_pc + 4, 64-bit wrap-around, no trap. Buffered entries carry their own PC.
- Redirect priority: fetch_flush over jmp_valid.
  - Target: fetch_pc <= target & ~64'h3.
  - misalign <= |target[1:0]. This updates on every redirect.
  - The buffer is cleared.
  - State goes to REQ, or stays WAIT if a request is outstanding.
- Discard flag:
  - Set when a redirect occurs while in WAIT, or in REQ with mem_gnt in the same cycle.
  - The next mem_rvalid is dropped and the flag clears.
  - The controller then moves to REQ at the new PC.
- Redirect in REQ without mem_gnt: mem_addr switches to the new target next cycle and mem_req stays high.
- Redirect in the same cycle as mem_rvalid with discard clear: the response is dropped and not enqueued.
- Dequeue and redirect in the same cycle: the dequeue occurs. Decode must kill it using its own flush.

## Timing
- Reset values:
  - mem_req=0, mem_addr=RESET_PC aligned, if_valid=0, if_instr=0, if_pc=0, misalign=0.
  - Discard flag 0, buffer empty, state IDLE.
- mem_req first asserts in the second cycle after reset deasserts.
- Latency: mem_rvalid in cycle N gives if_valid=1 in cycle N+1 (registered). Best case is grant -> rvalid -> if_valid over 3 consecutive cycles.
- Redirect in cycle N:
  - if_valid=0 in N+1.
  - mem_addr shows the new target in N+1 if no request is outstanding.
- Reset mid-operation clears everything immediately. A response arriving after reset for a pre-reset request is dropped, because the discard flag is set on reset whenever the prior state was WAIT.
- if_instr and if_pc are held stable while if_valid && !id_ready.

## Configuration
- FETCH_BUF2_EN defined: 2-entry FIFO instruction buffer. The next request may issue while one entry waits on decode, giving a sustained throughput of 1 instruction per 2 cycles with single-cycle memory.
- FETCH_BUF2_EN undefined: 1-entry buffer. No request issues while the entry is held unless it dequeues in that cycle.
- The interface is identical in both builds.

## Test plan
- Reset with RESET_PC=64'h1000, id_ready=1, memory gnt same cycle and rvalid next cycle:
  - mem_addr sequence 0x1000, 0x1000, 0x1008.
  - if_pc sequence 0x1000, 0x1004, 0x1008.
  - if_instr alternates rdata low/high halves.
- id_ready=0 for 5 cycles:
  - One fetch buffered without the macro, two with FETCH_BUF2_EN.
  - mem_req=0 while full.
  - Order preserved after release.
- jmp_valid with target 0x2000 while in WAIT:
  - The pending rvalid is dropped and if_valid stays 0.
  - Next mem_addr is 0x2000 and the first if_pc is 0x2000.
- jmp_valid target 0x3000 and fetch_flush target 0x4000 in the same cycle: the next fetch is at 0x4000.
- jmp_target 0x5002: misalign=1 and fetch from 0x5000. A subsequent jump to 0x6000 clears misalign.
- Assert reset while in WAIT, then the response arrives post-reset:
  - The response is dropped.
  - Fetch restarts at RESET_PC.
  - Outputs are at reset values during reset.
